// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - WIDTH-bit add/sub sequenced over one 4-bit adder slice
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int NSLICE = WIDTH / 4;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry;
    logic [KW-1:0]    k;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       nib;

    assign in_ready = (state == IDLE) && !rst;

    // The single shared adder slice, steered by the slice index.
    always_comb begin
        a_nib = a_r[{k, 2'b00} +: 4];
        b_nib = b_r[{k, 2'b00} +: 4];
        nib   = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            busy      <= 1'b0;
            k         <= '0;
            carry     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + ~borrow, so invert B and the carry-in here.
                        a_r   <= in_a;
                        b_r   <= in_sub ? ~in_b : in_b;
                        carry <= in_cin ^ in_sub;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    out_sum[{k, 2'b00} +: 4] <= nib[3:0];
                    carry <= nib[4];
                    k     <= k + 1'b1;
                    if (k == LAST_K) begin
                        out_cout  <= nib[4];
                        out_ovf   <= a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ nib[3] ^ nib[4];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - directed and random checks of nibble_serial_add_ctrl
module tb_nibble_serial_add_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    nibble_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic; returns {ovf, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        int ua, ub, sa, sb, u, s;
        logic cout, ovf;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            u    = ua - ub - int'(cin);
            s    = sa - sb - int'(cin);
            cout = (u >= 0);
        end else begin
            u    = ua + ub + int'(cin);
            s    = sa + sb + int'(cin);
            cout = (u > 65535);
        end
        ovf = (s > 32767) || (s < -32768);
        return {ovf, cout, u[W-1:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input logic keep_valid);
        int n;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_before_accept", in_ready, 1);
        tick();
        in_valid = keep_valid;
        in_a = W'($urandom);
        in_b = W'($urandom);
    endtask

    task automatic wait_result(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic sub, input string tag);
        int n;
        logic [W+1:0] exp;
        exp = model(a, b, cin, sub);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 4);
        check({tag, "_sum"}, out_sum, exp[W-1:0]);
        check({tag, "_cout"}, out_cout, exp[W]);
        check({tag, "_ovf"}, out_ovf, exp[W+1]);
    endtask

    task automatic full_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub, input string tag);
        send(a, b, cin, sub, 1'b0);
        wait_result(a, b, cin, sub, tag);
        tick();
        check({tag, "_valid_one_cycle"}, out_valid, 0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc, rs;
        logic [W+1:0] held;
        int           last_acc;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);

        full_op(16'h1234, 16'h4321, 1'b0, 1'b0, "add_basic");
        full_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "add_carry_chain");
        full_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "add_ovf");
        full_op(16'h0005, 16'h0007, 1'b0, 1'b1, "sub_borrow");
        full_op(16'h8000, 16'h0001, 1'b0, 1'b1, "sub_ovf");
        full_op(16'h0010, 16'h0001, 1'b1, 1'b1, "sub_cin");
        check("const_add_basic", model(16'h1234, 16'h4321, 1'b0, 1'b0), 18'h05555);

        // Backpressure in DONE
        out_ready = 1'b0;
        send(16'h0F0F, 16'h0101, 1'b1, 1'b0, 1'b0);
        wait_result(16'h0F0F, 16'h0101, 1'b1, 1'b0, "bp");
        held = model(16'h0F0F, 16'h0101, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            in_a = W'($urandom);
            in_b = W'($urandom);
            in_sub = 1'($urandom);
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_sum_stable", out_sum, held[W-1:0]);
            check("bp_flags_stable", {out_ovf, out_cout}, held[W+1:W]);
            check("bp_in_ready", in_ready, 0);
            check("bp_busy", busy, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        full_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, "bp_next");

        // Reset in the middle of RUN
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_sum", out_sum, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222;
        tick();
        check("rst_wins_busy", busy, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_no_result", out_valid, 0);
        end
        full_op(16'h0003, 16'h0004, 1'b0, 1'b0, "post_rst");

        // Back-to-back random traffic
        last_acc = 0;
        ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] ca, cb;
            logic         cc, cs;
            ca = ra; cb = rb; cc = rc; cs = rs;
            send(ca, cb, cc, cs, 1'b1);
            if (i > 0) check("b2b_spacing", cyc - last_acc, 6);
            last_acc = cyc;
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            in_a = ra; in_b = rb; in_cin = rc; in_sub = rs;
            wait_result(ca, cb, cc, cs, "b2b");
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("final_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
